// File: rtl/stream_demux_pkg.sv
// Shared defaults and slot-state encoding for the stream demultiplexer.
package stream_demux_pkg;

    localparam int DEF_DATA_W = 2;
    localparam int DEF_N_CH   = 2;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One output channel: single-entry holding register, its occupancy FSM and a
// wrapping count of completed transfers.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  cnt
);

    slot_state_t       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        drain   = (state_q == SLOT_FULL) & out_ready;

        // A load in the same cycle as a drain keeps the slot FULL with new data.
        case (state_q)
            SLOT_EMPTY: if (load) state_d = SLOT_FULL;
            SLOT_FULL:  if (drain & ~load) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase

        if (load)  data_d = load_data;
        if (drain) cnt_d  = cnt_q + CNT_W'(1);
    end

    assign out_valid = (state_q == SLOT_FULL);
    assign out_data  = data_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/stream_demux.sv
// Routes one valid/ready input stream to N_CH registered output channels,
// selected per beat; out-of-range selects are swallowed and flagged.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int N_CH   = DEF_N_CH,
    parameter  int CNT_W  = DEF_CNT_W,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic [N_CH*CNT_W-1:0]  out_cnt,
    output logic                   err_sel
);

    localparam logic [SEL_W:0] N_CH_L = (SEL_W+1)'(N_CH);

    logic [N_CH-1:0] sel_hit;
    logic [N_CH-1:0] slot_ok;
    logic [N_CH-1:0] load;
    logic            sel_bad;
    logic            err_sel_q, err_sel_d;

    // Never true when N_CH is a power of two.
    assign sel_bad  = ({1'b0, in_sel} >= N_CH_L);
    assign in_ready = sel_bad | (|slot_ok);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign sel_hit[k] = (in_sel == SEL_W'(k));
        assign slot_ok[k] = sel_hit[k] & (~out_valid[k] | out_ready[k]);
        assign load[k]    = in_valid & slot_ok[k];

        demux_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*DATA_W +: DATA_W]),
            .cnt       (out_cnt[k*CNT_W +: CNT_W])
        );
    end

    assign err_sel_d = err_sel_q | (in_valid & sel_bad);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_sel_q <= 1'b0;
        else     err_sel_q <= err_sel_d;
    end

    assign err_sel = err_sel_q;

endmodule

// File: tb/tb_stream_demux.sv
// Randomized scoreboard bench for stream_demux (2-channel main instance plus a
// 3-channel instance for illegal-select behaviour).
module tb_stream_demux;

    localparam int DW = 2;
    localparam int NC = 2;
    localparam int CW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [NC*DW-1:0] out_data;
    logic [NC-1:0]    out_valid;
    logic [NC-1:0]    out_ready;
    logic [NC*CW-1:0] out_cnt;
    logic             err_sel;

    logic [1:0]       in_data3;
    logic [1:0]       in_sel3;
    logic             in_valid3;
    logic             in_ready3;
    logic [5:0]       out_data3;
    logic [2:0]       out_valid3;
    logic [2:0]       out_ready3;
    logic [23:0]      out_cnt3;
    logic             err_sel3;

    stream_demux #(.DATA_W(DW), .N_CH(NC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_cnt(out_cnt),
        .err_sel(err_sel)
    );

    stream_demux #(.DATA_W(2), .N_CH(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_sel(in_sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_cnt(out_cnt3),
        .err_sel(err_sel3)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [DW-1:0] q [NC][$];   // beats accepted but not yet consumed, per channel
    int          cnt_exp [NC];  // completed transfers per channel
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NC; k++) begin
            q[k].delete();
            cnt_exp[k] = 0;
        end
    endtask

    // Monitor: one time unit before each rising edge, compare what the DUT
    // presents with the model, and retire any beat the consumer takes.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (mon_en && !rst) begin
                for (int k = 0; k < NC; k++) begin
                    check("out_valid", 64'(out_valid[k]), 64'(q[k].size() != 0));
                    if (q[k].size() != 0)
                        check("out_data", 64'(out_data[k*DW +: DW]), 64'(q[k][0]));
                    check("out_cnt", 64'(out_cnt[k*CW +: CW]), 64'(cnt_exp[k] % (1 << CW)));
                    if (q[k].size() != 0 && out_ready[k]) begin
                        void'(q[k].pop_front());
                        cnt_exp[k]++;
                    end
                end
            end
        end
    end

    // One cycle of stimulus; the model decides acceptance and queues the beat.
    task automatic drive(input bit v, input int sel, input logic [DW-1:0] d,
                         input logic [NC-1:0] rdy, output bit acc);
        bit exp_rdy;
        @(negedge clk);
        #1;
        in_valid  = v;
        in_sel    = sel[0];
        in_data   = d;
        out_ready = rdy;
        #2;
        exp_rdy = (q[sel].size() == 0) || rdy[sel];
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        if (acc && mon_en) q[sel].push_back(d);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        mon_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit            acc;
        bit            v;
        int            s;
        logic [DW-1:0] d;
        logic [NC-1:0] r;

        rst = 1'b1;
        in_valid = 1'b0; in_sel = 1'b0; in_data = '0; out_ready = '0;
        in_valid3 = 1'b0; in_sel3 = '0; in_data3 = '0; out_ready3 = '0;
        clear_model();
        #12;
        check("rst out_valid", 64'(out_valid), 64'(0));
        check("rst out_data", 64'(out_data), 64'(0));
        check("rst out_cnt", 64'(out_cnt), 64'(0));
        check("rst err_sel", 64'(err_sel3), 64'(0));
        check("rst in_ready", 64'(in_ready), 64'(1));
        release_reset();

        // Single beat to ch0 with all consumers ready
        drive(1, 0, 2'b01, 2'b11, acc);
        drive(0, 0, 2'b00, 2'b11, acc);
        drive(0, 0, 2'b00, 2'b11, acc);
        check("cnt0 after one drain", 64'(out_cnt[CW-1:0]), 64'(1));

        // Backpressure on ch1, isolation of ch0, then drain+load in one cycle
        drive(1, 1, 2'b10, 2'b01, acc);
        check("ch1 first accepted", 64'(acc), 64'(1));
        drive(1, 1, 2'b11, 2'b01, acc);
        check("ch1 second stalled", 64'(acc), 64'(0));
        drive(1, 0, 2'b01, 2'b01, acc);
        check("ch0 passes ch1 stall", 64'(acc), 64'(1));
        drive(1, 1, 2'b11, 2'b11, acc);
        check("ch1 drain+load", 64'(acc), 64'(1));
        check("ch1 stays valid", 64'(out_valid[1]), 64'(1));
        check("ch1 new data", 64'(out_data[2*DW-1:DW]), 64'(2'b11));
        drive(0, 0, 2'b00, 2'b11, acc);
        drive(0, 0, 2'b00, 2'b11, acc);

        // Randomized traffic; a refused beat is held until accepted
        v = 1'b0; acc = 1'b0;
        repeat (400) begin
            if (!(v && !acc)) begin
                v = ($urandom % 4) != 0;
                s = $urandom % NC;
                d = DW'($urandom);
            end
            r = NC'($urandom);
            drive(v, s, d, r, acc);
        end
        drive(0, 0, 2'b00, 2'b11, acc);
        drive(0, 0, 2'b00, 2'b11, acc);

        // Illegal and legal selects on the 3-channel instance
        @(negedge clk);
        #1;
        in_sel3 = 2'd3; in_data3 = 2'b11; in_valid3 = 1'b1; out_ready3 = 3'b000;
        #2;
        check("n3 illegal in_ready", 64'(in_ready3), 64'(1));
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        check("n3 illegal no valid", 64'(out_valid3), 64'(0));
        check("n3 err_sel set", 64'(err_sel3), 64'(1));
        @(negedge clk);
        #1;
        in_sel3 = 2'd2; in_data3 = 2'b10; in_valid3 = 1'b1;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        check("n3 ch2 valid", 64'(out_valid3), 64'(3'b100));
        check("n3 ch2 data", 64'(out_data3[5:4]), 64'(2'b10));
        repeat (3) @(posedge clk);
        #1;
        check("n3 err_sel sticky", 64'(err_sel3), 64'(1));

        // Fill both slots, then reset mid-cycle
        drive(1, 0, 2'b01, 2'b00, acc);
        drive(1, 1, 2'b10, 2'b00, acc);
        drive(0, 0, 2'b00, 2'b00, acc);
        check("both full", 64'(out_valid), 64'(2'b11));
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("async out_valid", 64'(out_valid), 64'(0));
        check("async out_cnt", 64'(out_cnt), 64'(0));
        check("async out_data", 64'(out_data), 64'(0));
        check("async err_sel", 64'(err_sel3), 64'(0));
        check("async n3 valid", 64'(out_valid3), 64'(0));
        check("async in_ready", 64'(in_ready), 64'(1));
        release_reset();

        // Full-rate stream into ch0; counter wraps after 256 drains
        for (int i = 0; i < 256; i++) begin
            drive(1, 0, DW'(i), 2'b11, acc);
            check("stream accept", 64'(acc), 64'(1));
        end
        drive(0, 0, 2'b00, 2'b11, acc);
        drive(0, 0, 2'b00, 2'b11, acc);
        check("cnt0 wrapped", 64'(out_cnt[CW-1:0]), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised, registered successor to the 1-to-2 combinational `demux`. It routes a `DATA_W`-bit input stream to one of `N_CH` output channels, selected per beat, using valid/ready handshakes. Each output channel has a one-entry holding register, so the block gives one-cycle latency and full throughput. It also keeps per-channel transfer counters and a sticky error flag for illegal selects. It sits between a single producer and several independent consumers in the datapath.

## Interface
- `DATA_W`, default 2: payload width.
- `N_CH`, default 2: number of output channels, ≥2.
- `CNT_W`, default 8: width of each per-channel transfer counter.
- `SEL_W`, derived localparam `$clog2(N_CH)`: select width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_data`  in  `DATA_W`  input payload.
- `in_sel`  in  `SEL_W`  destination channel for the current beat.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `out_data`  out  `N_CH*DATA_W`  packed channel payloads; channel k is at `[k*DATA_W +: DATA_W]`.
- `out_valid`  out  `N_CH`  per-channel valid.
- `out_ready`  in  `N_CH`  per-channel consumer ready.
- `out_cnt`  out  `N_CH*CNT_W`  packed per-channel completed-transfer counts.
- `err_sel`  out  1  sticky flag: a beat with `in_sel ≥ N_CH` was accepted.

## Operation
- Each channel slot is a 2-state FSM.
  - EMPTY → FULL on load.
  - FULL → EMPTY on drain (`out_valid[k] & out_ready[k]`) with no load.
  - FULL → FULL on simultaneous drain and load; the new data replaces the old.
- Accept condition: `in_ready = (in_sel ≥ N_CH) | ~full[in_sel] | out_ready[in_sel]`.
  - `in_ready` is combinational from `in_sel` and `out_ready`.
  - `in_ready` must not depend on `in_valid`.
- Load: `in_valid & in_ready & (in_sel < N_CH)` writes `in_data` into slot `in_sel`. No other slot changes.
- Illegal select: `in_valid & (in_sel ≥ N_CH)` is accepted and dropped. `err_sel` is set and stays 1 until `rst`. This case is only reachable when `N_CH` is not a power of two.
- Counters: `out_cnt[k]` increments by 1 on every drain of channel k. It wraps from `2^CNT_W−1` to 0 with no saturation or flag.
- Channels drain independently; several channels may drain in the same cycle.
- `out_data[k]` holds its last value while EMPTY. Consumers must qualify it with `out_valid[k]`.

## Timing
- Reset values while `rst` is high, and immediately on assertion:
  - all slots EMPTY, `out_valid = 0`
  - `out_data = 0`, `out_cnt = 0`, `err_sel = 0`
  - `in_ready` then follows its combinational equation, so it is 1 for any select.
- Latency: a beat accepted at edge t shows `out_valid[k]=1` and the data from edge t until the cycle after it drains.
- Throughput: one input beat per cycle. This holds even against a single channel, provided its consumer holds `out_ready` high.
- Backpressure: a FULL channel with `out_ready=0` stalls only beats addressed to it. Beats to other channels proceed.
- Reset mid-operation clears everything asynchronously and discards any held data. The first accept is possible on the first edge after deassertion.

## Structure
- Package `stream_demux_pkg` holds:
  - default values for `DATA_W`, `N_CH` and `CNT_W`;
  - a slot-state enum `slot_state_t {SLOT_EMPTY, SLOT_FULL}`.
- Sub-module `demux_slot`, instantiated `N_CH` times in a generate loop.
  - Ports: `clk`, `rst`, `load`, `load_data`, `out_ready`, `out_valid`, `out_data`, `cnt`.
  - Contents: the FSM, data register and counter for one channel.
- The top level contains only select decode, `in_ready` generation, `err_sel` and the output packing.

## Test plan
- Reset, then `in_valid=1`, `in_sel=0`, `in_data=2'b01`, all `out_ready=1` → next cycle `out_valid=2'b01`, channel 0 data `01`, `out_cnt[0]` becomes 1 after the drain edge.
- Block channel 1 (`out_ready[1]=0`), send two beats to ch1 (`10`, then `11`) → first beat accepted, second sees `in_ready=0` and is held. Raise `out_ready[1]` → `10` drains, `11` loads the same cycle, `out_valid[1]` stays 1.
- With ch1 blocked and FULL, send `01` to ch0 → accepted and delivered, showing per-channel isolation.
- Stream 256 beats to ch0 with `CNT_W=8` and ready held high → one beat per cycle, `out_cnt[0]` wraps to 0.
- `N_CH=3`, `in_sel=3`, `in_valid=1` → `in_ready=1`, no `out_valid` change, `err_sel=1` and it stays 1 until `rst`.
- Assert `rst` while both slots are FULL → `out_valid=0`, counters 0 and `err_sel=0` immediately, with no edge needed.
